// File: rtl/mp_addsub_iter_if.sv
// Operand/result bundle for the iterative multi-precision adder/subtractor.
// Latency and backpressure are properties of the attached engine (start/done handshake).
// master drives start/subtract/A/B and observes result/busy/done; slave is the engine side.
//
// Signals:
//   start    request, sampled by the engine only when it can accept
//   subtract 0 = A+B, 1 = A-B, sampled with start
//   A, B     WIDTH-bit operands, sampled with start
//   result   WIDTH+1-bit registered sum/difference
//   busy     operation in progress
//   done     one-cycle pulse, result valid
interface mp_addsub_iter_if #(
    parameter int WIDTH = 514
);
    logic             start;
    logic             subtract;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH:0]   result;
    logic             busy;
    logic             done;

    modport master (
        output start, subtract, A, B,
        input  result, busy, done
    );

    modport slave (
        input  start, subtract, A, B,
        output result, busy, done
    );
endinterface

// File: rtl/mp_addsub_iter.sv
// Iterative WIDTH-bit add/subtract, CHUNK bits per clock with a registered carry.
// Latency NCHUNK cycles from the accepting edge to done; one operation per NCHUNK cycles.
// No queueing: start is ignored while busy, except on the completion edge, where it is accepted.
//
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset; aborts any in-flight operation without a done
//   bus   slave side of mp_addsub_iter_if (start/subtract/A/B in, result/busy/done out)
module mp_addsub_iter #(
    parameter int WIDTH = 514,
    parameter int CHUNK = 128
) (
    input  logic                   clk,
    input  logic                   rstn,
    mp_addsub_iter_if.slave        bus
);
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW     = NCHUNK * CHUNK;   // padded operand width
    localparam int IW     = $clog2(PW);
    // Chunk counter is kept pre-scaled as the bit offset of the current slice.
    localparam logic [IW-1:0] LAST_BASE = IW'((NCHUNK - 1) * CHUNK);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [PW-1:0]    op_a;
    logic [PW-1:0]    op_b;
    logic [PW-1:0]    sum_q;
    logic             carry_q;
    logic             mode_q;
    logic [IW-1:0]    base_q;
    logic [WIDTH:0]   result_q;
    logic             busy_q;
    logic             done_q;

    logic [CHUNK:0]   slice_sum;
    logic [PW-1:0]    sum_next;
    logic [PW:0]      sum_full;
    logic [WIDTH:0]   res_next;
    logic [WIDTH-1:0] b_eff;
    logic             last;
    logic             accept;

    always_comb begin
        last      = (state == BUSY) && (base_q == LAST_BASE);
        // The completion edge doubles as an accept edge so a held start runs back-to-back.
        accept    = bus.start && ((state == IDLE) || last);
        // Inverted before zero-extension: pad bits of ~B must stay zero.
        b_eff     = bus.subtract ? ~bus.B : bus.B;

        slice_sum = {1'b0, op_a[base_q +: CHUNK]} + {1'b0, op_b[base_q +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};
        sum_next  = sum_q;
        sum_next[base_q +: CHUNK] = slice_sum[CHUNK-1:0];
        sum_full  = {slice_sum[CHUNK], sum_next};

        // Bit WIDTH is the carry into that position: with zero pads it is a plain sum bit
        // of the top chunk; without pads it is the chunk carry-out. Subtract inverts it to
        // report the unsigned borrow.
        res_next  = {sum_full[WIDTH] ^ mode_q, sum_full[WIDTH-1:0]};
    end

    if (PW > WIDTH) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^sum_full[PW:WIDTH+1];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            mode_q   <= 1'b0;
            base_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == BUSY) begin
                sum_q   <= sum_next;
                carry_q <= slice_sum[CHUNK];
                base_q  <= base_q + IW'(CHUNK);
                if (last) begin
                    result_q <= res_next;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    base_q   <= '0;
                    state    <= IDLE;
                end
            end
            if (accept) begin
                op_a    <= PW'(bus.A);
                op_b    <= PW'(b_eff);
                carry_q <= bus.subtract;
                mode_q  <= bus.subtract;
                base_q  <= '0;
                busy_q  <= 1'b1;
                state   <= BUSY;
            end
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_mp_addsub_iter.sv
// Bench for mp_addsub_iter: default 514/128 instance, non-divisible 8/3, and single-chunk 8/8.
// Expected results are queued when an operation is accepted and compared when done pulses.
// Inputs are driven away from the rising edge; outputs are sampled on the falling edge or #1 after.
module tb_mp_addsub_iter;
    logic clk;
    logic rstn;
    int   cmp = 0;
    int   err = 0;
    int   cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    mp_addsub_iter_if #(.WIDTH(514)) bi ();
    mp_addsub_iter_if #(.WIDTH(8))   si ();
    mp_addsub_iter_if #(.WIDTH(8))   ui ();

    mp_addsub_iter #(.WIDTH(514), .CHUNK(128)) u_big (.clk(clk), .rstn(rstn), .bus(bi));
    mp_addsub_iter #(.WIDTH(8),   .CHUNK(3))   u_sml (.clk(clk), .rstn(rstn), .bus(si));
    mp_addsub_iter #(.WIDTH(8),   .CHUNK(8))   u_one (.clk(clk), .rstn(rstn), .bus(ui));

    typedef struct {
        logic [514:0] exp;
        int           t;
    } sb_t;

    sb_t big_q[$];
    sb_t sml_q[$];
    sb_t one_q[$];

    typedef struct packed {
        logic         sub;
        logic [513:0] a;
        logic [513:0] b;
        logic [514:0] exp;
    } vec_t;

    vec_t vt[7];

    task automatic chk_vec(input string nm, input logic [514:0] act, input logic [514:0] exp);
        cmp++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        cmp++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard monitors: every done must match the oldest queued expectation.
    always @(negedge clk) begin
        sb_t e;
        if (bi.done) begin
            if (big_q.size() == 0) chk_int("big_spurious_done", 1, 0);
            else begin
                e = big_q.pop_front();
                chk_vec("big_result", bi.result, e.exp);
                chk_int("big_latency", cyc - e.t, 5);
            end
        end
        if (si.done) begin
            if (sml_q.size() == 0) chk_int("sml_spurious_done", 1, 0);
            else begin
                e = sml_q.pop_front();
                chk_vec("sml_result", 515'(si.result), e.exp);
                chk_int("sml_latency", cyc - e.t, 3);
            end
        end
        if (ui.done) begin
            if (one_q.size() == 0) chk_int("one_spurious_done", 1, 0);
            else begin
                e = one_q.pop_front();
                chk_vec("one_result", 515'(ui.result), e.exp);
                chk_int("one_latency", cyc - e.t, 1);
            end
        end
    end

    // One full operation on the default instance with handshake timing checks.
    task automatic run_big(input logic sub, input logic [513:0] a, input logic [513:0] b,
                           input logic [514:0] exp, input int idx);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        bi.start = 1'b1; bi.subtract = sub; bi.A = a; bi.B = b;
        @(posedge clk); #1;
        big_q.push_back('{exp: exp, t: cyc});
        bi.start = 1'b0; bi.subtract = ~sub; bi.A = ~a; bi.B = ~b;
        lat = 0;
        busy_ok = 1'b1;
        while (!bi.done && lat < 20) begin
            if (!bi.busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk_int($sformatf("vec%0d_done_edge", idx), lat, 5);
        chk_int($sformatf("vec%0d_busy_held", idx), int'(busy_ok), 1);
        chk_int($sformatf("vec%0d_busy_at_done", idx), int'(bi.busy), 0);
        @(posedge clk); #1;
        chk_int($sformatf("vec%0d_done_pulse", idx), int'(bi.done), 0);
    endtask

    initial begin
        logic [513:0] ones;
        logic [514:0] hold_exp;
        logic         stable;
        int           lat;
        int           mask;
        int           seen;

        bi.start = 1'b0; bi.subtract = 1'b0; bi.A = '0; bi.B = '0;
        si.start = 1'b0; si.subtract = 1'b0; si.A = '0; si.B = '0;
        ui.start = 1'b0; ui.subtract = 1'b0; ui.A = '0; ui.B = '0;

        ones = '1;
        vt[0] = '{sub: 1'b0, a: 514'd3, b: 514'd5, exp: 515'd8};
        vt[1] = '{sub: 1'b0, a: (514'(1) << 128) - 514'd1, b: 514'd1, exp: 515'(1) << 128};
        vt[2] = '{sub: 1'b0, a: ones, b: ones, exp: {ones, 1'b0}};
        vt[3] = '{sub: 1'b1, a: 514'd5, b: 514'd7, exp: {1'b1, ones - 514'd1}};
        vt[4] = '{sub: 1'b1, a: 514'h1234, b: 514'h1234, exp: 515'd0};
        vt[5] = '{sub: 1'b1, a: 514'(1) << 300, b: 514'd1, exp: {1'b0, (514'(1) << 300) - 514'd1}};
        vt[6] = '{sub: 1'b0, a: ones, b: 514'd1, exp: 515'(1) << 514};

        rstn = 1'b1;
        #1 rstn = 1'b0;
        #2;
        chk_vec("rst_big_result", bi.result, 515'd0);
        chk_int("rst_big_busy", int'(bi.busy), 0);
        chk_int("rst_big_done", int'(bi.done), 0);
        chk_vec("rst_sml_result", 515'(si.result), 515'd0);
        chk_vec("rst_one_result", 515'(ui.result), 515'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 7; i++)
            run_big(vt[i].sub, vt[i].a, vt[i].b, vt[i].exp, i);

        // start held high: accepts on edges 0, 5, 10; done on 5, 10, 15.
        @(negedge clk);
        bi.start = 1'b1; bi.subtract = 1'b0; bi.A = 514'd10; bi.B = 514'd3;
        @(posedge clk); #1;
        big_q.push_back('{exp: 515'd13, t: cyc});
        mask = 0;
        for (int e = 1; e <= 18; e++) begin
            @(posedge clk); #1;
            if (bi.done) mask = mask | (1 << e);
            if (e == 5 || e == 10) big_q.push_back('{exp: 515'd13, t: cyc});
            if (e == 10) bi.start = 1'b0;
        end
        chk_int("held_start_done_edges", mask, (1 << 5) | (1 << 10) | (1 << 15));

        // A start pulse at edge 2 with other operands must not disturb the running op.
        @(negedge clk);
        bi.start = 1'b1; bi.subtract = 1'b0; bi.A = 514'd100; bi.B = 514'd23;
        @(posedge clk); #1;
        big_q.push_back('{exp: 515'd123, t: cyc});
        bi.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bi.start = 1'b1; bi.subtract = 1'b1; bi.A = 514'd999; bi.B = 514'd1;
        @(posedge clk); #1;
        bi.start = 1'b0;
        lat = 2;
        while (!bi.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk_int("busy_start_ignored_done_edge", lat, 5);
        repeat (8) @(posedge clk);

        // Result holds through idle cycles.
        hold_exp = 515'h77;
        run_big(1'b0, 514'h55, 514'h22, hold_exp, 7);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bi.result !== hold_exp) stable = 1'b0;
        end
        chk_int("result_stable_idle", int'(stable), 1);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        bi.start = 1'b1; bi.subtract = 1'b0; bi.A = 514'd77; bi.B = 514'd11;
        @(posedge clk); #1;
        bi.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk_vec("midop_rst_result", bi.result, 515'd0);
        chk_int("midop_rst_busy", int'(bi.busy), 0);
        chk_int("midop_rst_done", int'(bi.done), 0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bi.done) seen++;
        end
        chk_int("midop_rst_no_done", seen, 0);
        run_big(1'b0, 514'd77, 514'd11, 515'd88, 8);

        // Non-divisible 8/3 instance: every A, both modes, boundary and random B.
        for (int a = 0; a < 256; a++) begin
            for (int s = 0; s < 2; s++) begin
                for (int k = 0; k < 14; k++) begin
                    logic [7:0] av;
                    logic [7:0] bv;
                    logic [8:0] ev;
                    av = 8'(a);
                    case (k)
                        0:       bv = 8'd0;
                        1:       bv = 8'd1;
                        2:       bv = 8'd127;
                        3:       bv = 8'd128;
                        4:       bv = 8'd254;
                        5:       bv = 8'd255;
                        6:       bv = av;
                        7:       bv = ~av;
                        8:       bv = av + 8'd1;
                        default: bv = 8'($urandom_range(0, 255));
                    endcase
                    if (s == 1) ev = {av < bv, av - bv};
                    else        ev = {1'b0, av} + {1'b0, bv};
                    @(negedge clk);
                    si.start = 1'b1; si.subtract = (s == 1); si.A = av; si.B = bv;
                    @(posedge clk); #1;
                    sml_q.push_back('{exp: 515'(ev), t: cyc});
                    si.start = 1'b0; si.A = ~av;
                    @(posedge clk);
                    @(posedge clk);
                end
            end
        end
        repeat (5) @(posedge clk);

        // Single-chunk instance: start held, one operation per cycle.
        for (int k = 0; k < 64; k++) begin
            logic [7:0] av;
            logic [7:0] bv;
            logic       sv;
            logic [8:0] ev;
            av = 8'($urandom_range(0, 255));
            bv = (k < 4) ? 8'hFF : 8'($urandom_range(0, 255));
            sv = k[0];
            if (sv) ev = {av < bv, av - bv};
            else    ev = {1'b0, av} + {1'b0, bv};
            @(negedge clk);
            ui.start = 1'b1; ui.subtract = sv; ui.A = av; ui.B = bv;
            @(posedge clk); #1;
            one_q.push_back('{exp: 515'(ev), t: cyc});
        end
        @(negedge clk);
        ui.start = 1'b0;

        repeat (10) @(posedge clk);
        #1;
        chk_int("big_queue_drained", big_q.size(), 0);
        chk_int("sml_queue_drained", sml_q.size(), 0);
        chk_int("one_queue_drained", one_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
